matrix_mem_server: RTL

- Memory-side responder for the systemizer's word-addressed matrix port.
- Owns the matrix RAM and serves systemizer reads and writes.
- Provides a byte-wide host path to load the matrix before a run, launch the run, and stream the reduced matrix back afterwards.
- Sits between the top-level pin wrapper and the systemizer. The systemizer is the initiator; this block is the responder.

---
 rtl/matrix_mem_server.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/matrix_mem_server.sv
// matrix_mem_server: matrix RAM owner, systemizer responder and byte-wide host loader/dumper.
// Optional WRITE_FORWARD_EN: same-cycle read/write to one address returns the new data.
module matrix_mem_server #(
  parameter int BLOCK  = 4,
  parameter int DEPTH  = 40,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic [1:0]        status,
  output logic              start,
  input  logic              done,
  input  logic              fail,
  input  logic              success,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BLOCK-1:0]  data_out,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BLOCK-1:0]  data_in
);

  localparam int BPW = (BLOCK + 7) / 8;
  localparam int WB  = 8 * BPW;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [ADDR_W-1:0] LAST_W  = ADDR_W'(DEPTH - 1);
  localparam logic [BCW-1:0]    LAST_B  = BCW'(BPW - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_PULSE,
    S_RUN_WAIT,
    S_DUMP_RD,
    S_DUMP_TX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [BLOCK-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [BCW-1:0]    bcnt;
  logic [WB-1:0]     wbuf;
  logic [WB-1:0]     load_word;
  logic [WB-1:0]     rd_word;
  logic [WB-1:0]     tx_word;
  logic              clash;
  logic              clash_nx;

  logic in_fire;
  logic out_fire;
  logic last_byte;
  logic host_wr;
  logic sys_wr;
  logic sys_rd_ok;

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DUMP_TX);
  assign start     = (state == S_RUN_PULSE);

  assign in_fire   = in_ready && in_valid;
  assign out_fire  = out_valid && out_ready;
  assign last_byte = (bcnt == LAST_B);
  assign host_wr   = in_fire && last_byte;
  assign sys_wr    = wr_en && ({1'b0, wr_addr} < DEPTH_X);
  assign sys_rd_ok = {1'b0, rd_addr} < DEPTH_X;
  assign clash_nx  = clash || (host_wr && sys_wr);

  // Bytes arrive LSB-first, so each new byte shifts in from the top.
  always_comb begin
    load_word = WB'({in_data, wbuf} >> 8);
    rd_word   = WB'(mem[ptr]);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            2'b01:   state_nx = S_LOAD;
            2'b10:   state_nx = S_RUN_PULSE;
            2'b11:   state_nx = S_DUMP_RD;
            default: state_nx = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (host_wr && ptr == LAST_W) state_nx = S_IDLE;
      end
      S_RUN_PULSE: state_nx = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (done) state_nx = S_IDLE;
      end
      S_DUMP_RD: state_nx = S_DUMP_TX;
      S_DUMP_TX: begin
        if (out_fire && last_byte)
          state_nx = (ptr == LAST_W) ? S_IDLE : S_DUMP_RD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The systemizer write always wins the single RAM write port.
  always_ff @(posedge clk) begin
    if (sys_wr)
      mem[wr_addr] <= data_in;
    else if (host_wr)
      mem[ptr] <= BLOCK'(load_word);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_en) begin
      if (!sys_rd_ok)
        data_out <= '0;
`ifdef WRITE_FORWARD_EN
      else if (wr_en && wr_addr == rd_addr)
        data_out <= data_in;
`endif
      else
        data_out <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      bcnt     <= '0;
      wbuf     <= '0;
      tx_word  <= '0;
      out_data <= '0;
      status   <= '0;
      clash    <= 1'b0;
    end else begin
      state <= state_nx;
      clash <= clash_nx;
      unique case (state)
        S_IDLE: begin
          ptr  <= '0;
          bcnt <= '0;
          wbuf <= '0;
        end
        S_LOAD: begin
          if (in_fire) begin
            if (last_byte) begin
              bcnt <= '0;
              wbuf <= '0;
              ptr  <= ptr + 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
              wbuf <= load_word;
            end
          end
        end
        S_RUN_PULSE: status <= 2'b00;
        S_RUN_WAIT: begin
          if (done) status <= {fail, success};
        end
        S_DUMP_RD: begin
          tx_word  <= rd_word;
          out_data <= rd_word[7:0];
          bcnt     <= '0;
        end
        S_DUMP_TX: begin
          if (out_fire) begin
            if (last_byte) begin
              bcnt <= '0;
              ptr  <= ptr + 1'b1;
            end else begin
              bcnt     <= bcnt + 1'b1;
              tx_word  <= tx_word >> 8;
              out_data <= 8'(tx_word >> 8);
            end
          end
        end
        default: ;
      endcase
      // A dropped host write is reported once the host operation ends.
      if (clash_nx && state != S_IDLE && state_nx == S_IDLE) begin
        status <= 2'b11;
        clash  <= 1'b0;
      end
    end
  end

endmodule
